seq_generator: RTL and testbench

Serial pattern generator that emits a programmed bit pattern, MSB first, one bit per clock on `dout`, optionally repeated with a programmable idle gap between repetitions. It is the transmit end of the single-bit serial stream consumed by the team's serial sequence detector. It is also the stimulus source for that detector in system-level benches. A host loads a pattern, length and repeat count through a valid/ready handshake, and the block reports completion with a one-cycle `done` pulse.

---
 rtl/seq_generator_if.sv | 28 ++
 rtl/seq_generator.sv | 117 +++++++++++
 tb/tb_seq_generator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_generator_if.sv
// Load handshake and serial output bundle between a host and seq_generator.
// Lengths are carried in $clog2(WIDTH+1) bits so that WIDTH itself is expressible.
interface seq_generator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_cnt;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, pattern, len, repeat_cnt,
        input  load_ready, dout, dout_valid, busy, done
    );

    modport slave (
        input  load_valid, pattern, len, repeat_cnt,
        output load_ready, dout, dout_valid, busy, done
    );
endinterface

// File: rtl/seq_generator.sv
// Serial pattern generator: sends a captured pattern MSB first, repeated
// repeat_cnt+1 times with an optional fixed idle gap between repetitions.
module seq_generator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic          clk,
    input  logic          rst,
    seq_generator_if.slave bus
);
    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic               dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   len_eff;
    logic               gap_last;

    assign len_eff = (bus.len == '0 || bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] gap_q;
            // Counter sits preloaded outside GAP so the first gap cycle sees GAP.
            always_ff @(posedge clk) begin
                if (rst || state_q != S_GAP) gap_q <= GW'(GAP);
                else                         gap_q <= gap_q - GW'(1);
            end
            assign gap_last = (gap_q == GW'(1));
        end else begin : g_nogap
            assign gap_last = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        last_d  = last_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load_valid) begin
                    pat_d   = bus.pattern;
                    last_d  = IDX_W'(len_eff - LEN_W'(1));
                    idx_d   = IDX_W'(len_eff - LEN_W'(1));
                    rep_d   = bus.repeat_cnt;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (idx_q == '0) begin
                    if (rep_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        rep_d   = rep_q - CNT_W'(1);
                        idx_d   = last_q;
                        state_d = (GAP > 0) ? S_GAP : S_SEND;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_GAP: begin
                if (gap_last) state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state will present.
        vld_d  = (state_d == S_SEND);
        dout_d = vld_d & pat_d[idx_d];
        done_d = vld_d && (idx_d == '0) && (rep_d == '0);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.load_ready = (state_q == S_IDLE) & ~rst;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_seq_generator.sv
// Directed bench: two generators (GAP=0 and GAP=2) share one stimulus; each
// cycle's {busy,done,dout_valid,dout} nibble is checked against hand vectors.
module tb_seq_generator;
    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic [7:0] pat;
    logic [3:0] ln;
    logic [3:0] rc;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    seq_generator_if #(.WIDTH(8), .CNT_W(4)) ifc0 ();
    seq_generator_if #(.WIDTH(8), .CNT_W(4)) ifc2 ();

    assign ifc0.load_valid = lv;
    assign ifc0.pattern    = pat;
    assign ifc0.len        = ln;
    assign ifc0.repeat_cnt = rc;
    assign ifc2.load_valid = lv;
    assign ifc2.pattern    = pat;
    assign ifc2.len        = ln;
    assign ifc2.repeat_cnt = rc;

    seq_generator #(.WIDTH(8), .CNT_W(4), .GAP(0)) u_g0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
    seq_generator #(.WIDTH(8), .CNT_W(4), .GAP(2)) u_g2 (.clk(clk), .rst(rst), .bus(ifc2.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cyc(input string tag, input int c, input logic [3:0] e0, input logic [3:0] e2);
        chk($sformatf("%s_g0_c%0d", tag, c), {ifc0.busy, ifc0.done, ifc0.dout_valid, ifc0.dout}, e0);
        chk($sformatf("%s_g2_c%0d", tag, c), {ifc2.busy, ifc2.done, ifc2.dout_valid, ifc2.dout}, e2);
    endtask

    // Nibbles listed chronologically, cycle 1 in the most significant position.
    task automatic run(input string tag, input int n, input logic [255:0] e0, input logic [255:0] e2);
        for (int c = 0; c < n; c++) begin
            if (c > 0) step();
            chk_cyc(tag, c + 1, e0[4*(n-1-c) +: 4], e2[4*(n-1-c) +: 4]);
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        lv  = 1'b1;
        pat = p;
        ln  = l;
        rc  = r;
        step();
        lv  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lv = 1'b1; pat = 8'hFF; ln = 4'd8; rc = 4'd0;

        // Reset held two cycles with a pending load
        for (int c = 1; c <= 2; c++) begin
            step();
            chk_cyc("rst", c, 4'h0, 4'h0);
            chk("rst_rdy0", ifc0.load_ready, 1'b0);
            chk("rst_rdy2", ifc2.load_ready, 1'b0);
        end
        rst = 1'b0; lv = 1'b0;
        step();
        chk("rel_rdy0", ifc0.load_ready, 1'b1);
        chk("rel_rdy2", ifc2.load_ready, 1'b1);
        chk_cyc("rel", 1, 4'h0, 4'h0);

        // Basic frame 101
        load(8'h05, 4'd3, 4'd0);
        run("basic", 4, 256'hBAF0, 256'hBAF0);

        // Three repetitions: back-to-back vs two-cycle gap
        load(8'h05, 4'd3, 4'd2);
        run("rep", 14, 256'hBABBABBAF00000, 256'hBAB88BAB88BAF0);

        // len=0 and len>WIDTH clamp to 8 bits
        load(8'hA5, 4'd0, 4'd0);
        run("len0", 9, 256'hBABAABAF0, 256'hBABAABAF0);
        load(8'hA5, 4'd12, 4'd0);
        run("len12", 9, 256'hBABAABAF0, 256'hBABAABAF0);

        // Single-bit frame
        load(8'h01, 4'd1, 4'd0);
        run("len1", 2, 256'hF0, 256'hF0);

        // load_valid held with scrambled inputs, next load right after done
        lv = 1'b1; pat = 8'h2D; ln = 4'd4; rc = 4'd0;
        step();
        for (int c = 1; c <= 8; c++) begin
            logic [31:0] v;
            v = 32'hBBAF_0BF0;
            chk_cyc("hold", c, v[4*(8-c) +: 4], v[4*(8-c) +: 4]);
            if (c == 4) chk("hold_rdy_done", ifc0.load_ready, 1'b0);
            if (c == 5) chk("hold_rdy_after", ifc0.load_ready, 1'b1);
            if (c <= 3) begin
                pat = 8'($urandom); ln = 4'($urandom); rc = 4'($urandom);
            end
            if (c == 4) begin
                pat = 8'h03; ln = 4'd2; rc = 4'd0;
            end
            if (c == 6) lv = 1'b0;
            step();
        end

        // Reset during the second of three repetitions
        load(8'h05, 4'd3, 4'd2);
        run("mid", 7, 256'hBABBABB, 256'hBAB88BA);
        rst = 1'b1;
        step();
        chk_cyc("mid_rst", 1, 4'h0, 4'h0);
        chk("mid_rst_rdy", ifc2.load_ready, 1'b0);
        rst = 1'b0;
        step();
        chk("mid_rel_rdy", ifc2.load_ready, 1'b1);
        run("mid_quiet", 3, 256'h000, 256'h000);
        load(8'h06, 4'd3, 4'd0);
        run("fresh", 4, 256'hBBE0, 256'hBBE0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
